pio_n_in: RTL and testbench
===========================

Name: pio_n_in

Overview:
Avalon-MM slave that brings an external N-bit input bus into the HPS/Nios address space. It is the read-side counterpart of the write-only PIO output register. The block does the following:
- Synchronizes the inputs into clk.
- Exposes the live value and latches per-bit edge events in a capture register.
- Raises a level interrupt for unmasked captured edges.

Parameters:
bus_width, 32, width of pio_in, readdata and writedata
edge_type, 0, edge to capture: 0 = rising, 1 = falling, 2 = any

Ports:
clk  input  1  system clock; all state on its rising edge
reset_n  input  1  asynchronous, active-low reset
avs_s0_address  input  2  register select: 0 data, 1 reserved, 2 irq mask, 3 edge capture
avs_s0_read  input  1  read strobe, single-cycle, no waitrequest
avs_s0_readdata  output  bus_width  read data, fixed read latency 1
avs_s0_write  input  1  write strobe, single-cycle, no waitrequest
avs_s0_writedata  input  bus_width  write data
pio_in  input  bus_width  asynchronous external inputs
irq  output  1  level interrupt to processor

Behaviour:
- Reset (reset_n low, asynchronous): all of the following clear to 0 immediately and hold while reset_n is low:
  - sync1, sync2, prev, mask, capture, settle counter, avs_s0_readdata, irq.
- Synchronizer:
  - Each clk: sync1 <= pio_in; sync2 <= sync1; prev <= sync2.
  - A pio_in change set up before edge k appears in sync2 after edge k+1.
- Settle counter:
  - 2-bit saturating counter.
  - Increments each clk after reset release and stops at 3.
  - Edge detection is disabled while the count is below 3. This masks spurious edges from the 0-initialized chain; e.g. pio_in held high through reset sets no capture.
- Edge detect (per bit, when enabled):
  - rising = sync2 & ~prev
  - falling = ~sync2 & prev
  - any = sync2 ^ prev
  - Selected by edge_type.
- Capture register (address 3):
  - capture <= (capture & ~clr) | det, where clr = writedata when writing address 3, else 0.
  - Write-1-to-clear; writing 0 leaves a bit untouched.
  - Same-cycle new edge and clear on the same bit: the edge wins and the bit stays 1.
  - Latency: pio_in change before edge k sets the capture bit after edge k+2.
- Mask register (address 2): read/write, full width, loaded on write.
- Address 0 (data): writes are ignored.
- Address 1 (reserved): writes are ignored; reads return 0.
- Read path:
  - On edge with avs_s0_read high, avs_s0_readdata <= the selected value: sync2 / 0 / mask / capture.
  - Valid in the cycle after the read strobe; holds its value when no read is issued.
  - A capture read in the same cycle as a new edge returns the pre-update capture value.
- Simultaneous read and write: both are performed; the read returns the pre-write register value.
- irq = |(capture & mask), driven from flops with no extra register stage. It stays high until every unmasked captured bit is cleared or masked.
- Reset mid-operation: all state clears asynchronously, including pending capture and irq. After release, the 3-cycle settle applies again.

Test Plan:
1. Reset with pio_in = 0xFFFFFFFF, release, wait 10 cycles; read addr 3 -> 0x00000000, irq = 0; read addr 0 -> 0xFFFFFFFF.
2. edge_type = 0: pio_in 0x0 -> 0x0000_00A5 before edge k -> capture = 0x0000_00A5 after edge k+2; mask = 0x1 -> irq = 1; write 0x1 to addr 3 -> capture 0x0000_00A4, irq = 0.
3. Falling edge on bit 3 in the same cycle as a write of 0x8 to addr 3, edge_type = 1 -> bit 3 remains 1.
4. Read addr 0 at edge k with pio_in stable at 0x1234_5678 -> readdata = 0x1234_5678 one cycle later; read addr 1 -> 0.
5. edge_type = 2: toggle bit 31 twice, 5 cycles apart -> capture bit 31 set once, stays set until cleared.
6. Assert reset_n low mid-cycle with capture = 0xF and irq = 1 -> capture, mask, irq and readdata go to 0 without waiting for a clk edge.

Source files
------------

// File: rtl/pio_n_in.sv
// Avalon-MM input PIO: synchronizes an external bus, latches per-bit edges
// in a write-1-to-clear capture register and raises a masked level interrupt.
module pio_n_in #(
  parameter int bus_width = 32,
  parameter int edge_type = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           avs_s0_address,
  input  logic                 avs_s0_read,
  output logic [bus_width-1:0] avs_s0_readdata,
  input  logic                 avs_s0_write,
  input  logic [bus_width-1:0] avs_s0_writedata,
  input  logic [bus_width-1:0] pio_in,
  output logic                 irq
);

  logic [bus_width-1:0] sync1;
  logic [bus_width-1:0] sync2;
  logic [bus_width-1:0] prev;
  logic [bus_width-1:0] mask;
  logic [bus_width-1:0] capture;
  logic [1:0]           settle;
  logic [bus_width-1:0] det;
  logic [bus_width-1:0] clr;
  logic [bus_width-1:0] rd_sel;

  // Edge detection stays off until the zero-initialized chain has filled with real samples.
  always_comb begin
    det = '0;
    if (settle == 2'd3) begin
      case (edge_type)
        0:       det = sync2 & ~prev;
        1:       det = ~sync2 & prev;
        default: det = sync2 ^ prev;
      endcase
    end
  end

  always_comb begin
    clr = '0;
    if (avs_s0_write && (avs_s0_address == 2'd3)) begin
      clr = avs_s0_writedata;
    end
  end

  always_comb begin
    case (avs_s0_address)
      2'd0:    rd_sel = sync2;
      2'd2:    rd_sel = mask;
      2'd3:    rd_sel = capture;
      default: rd_sel = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1           <= '0;
      sync2           <= '0;
      prev            <= '0;
      mask            <= '0;
      capture         <= '0;
      settle          <= 2'd0;
      avs_s0_readdata <= '0;
    end else begin
      sync1 <= pio_in;
      sync2 <= sync1;
      prev  <= sync2;
      if (settle != 2'd3) begin
        settle <= settle + 2'd1;
      end
      // A new edge on a bit being cleared in the same cycle keeps the bit set.
      capture <= (capture & ~clr) | det;
      if (avs_s0_write && (avs_s0_address == 2'd2)) begin
        mask <= avs_s0_writedata;
      end
      if (avs_s0_read) begin
        avs_s0_readdata <= rd_sel;
      end
    end
  end

  assign irq = |(capture & mask);

endmodule

// File: tb/tb_pio_n_in.sv
// Self-checking bench for pio_n_in: one instance per edge type sharing the bus,
// checked against a sample-history reference model plus directed constants.
module tb_pio_n_in;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] pio_in;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int compared;
  int mismatched;

  pio_n_in #(.bus_width(32), .edge_type(0)) dut_rise (
    .clk(clk), .reset_n(reset_n), .avs_s0_address(address), .avs_s0_read(read),
    .avs_s0_readdata(rd0), .avs_s0_write(write), .avs_s0_writedata(writedata),
    .pio_in(pio_in), .irq(irq0)
  );

  pio_n_in #(.bus_width(32), .edge_type(1)) dut_fall (
    .clk(clk), .reset_n(reset_n), .avs_s0_address(address), .avs_s0_read(read),
    .avs_s0_readdata(rd1), .avs_s0_write(write), .avs_s0_writedata(writedata),
    .pio_in(pio_in), .irq(irq1)
  );

  pio_n_in #(.bus_width(32), .edge_type(2)) dut_any (
    .clk(clk), .reset_n(reset_n), .avs_s0_address(address), .avs_s0_read(read),
    .avs_s0_readdata(rd2), .avs_s0_write(write), .avs_s0_writedata(writedata),
    .pio_in(pio_in), .irq(irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pio_in sampled at edge n becomes visible as the data value
  // two edges later, and an edge between consecutive visible samples is captured
  // once three full samples have been taken since reset release.
  int          n_edges;
  logic [31:0] hist [0:4095];
  logic [31:0] m_cap [3];
  logic [31:0] m_rd [3];
  logic [31:0] m_mask;

  function automatic logic [31:0] samp(input int i);
    if (i < 1) return 32'h0;
    return hist[i % 4096];
  endfunction

  function automatic logic [31:0] edge_fn(input int e, input logic [31:0] now_v, input logic [31:0] old_v);
    if (e == 0) return now_v & ~old_v;
    if (e == 1) return ~now_v & old_v;
    return now_v ^ old_v;
  endfunction

  function automatic logic [31:0] det_val(input int e, input int n);
    if (n < 4) return 32'h0;
    return edge_fn(e, samp(n - 2), samp(n - 3));
  endfunction

  function automatic logic [31:0] rd_val(input int e, input int n, input logic [1:0] a);
    case (a)
      2'd0:    return samp(n - 2);
      2'd2:    return m_mask;
      2'd3:    return m_cap[e];
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_edges <= 0;
      m_mask  <= 32'h0;
      for (int e = 0; e < 3; e++) begin
        m_cap[e] <= 32'h0;
        m_rd[e]  <= 32'h0;
      end
    end else begin
      for (int e = 0; e < 3; e++) begin
        m_cap[e] <= (m_cap[e] & ~((write && address == 2'd3) ? writedata : 32'h0))
                    | det_val(e, n_edges + 1);
        if (read) m_rd[e] <= rd_val(e, n_edges + 1, address);
      end
      if (write && address == 2'd2) m_mask <= writedata;
      hist[(n_edges + 1) % 4096] <= pio_in;
      n_edges <= n_edges + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic rd, input logic wr, input logic [1:0] a, input logic [31:0] d);
    read      = rd;
    write     = wr;
    address   = a;
    writedata = d;
  endtask

  task automatic do_read(input logic [1:0] a);
    apply_stimulus(1'b1, 1'b0, a, 32'h0);
    tick();
    apply_stimulus(1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    apply_stimulus(1'b0, 1'b1, a, d);
    tick();
    apply_stimulus(1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check_output({tag, "/rd_rise"}, rd0, m_rd[0]);
    check_output({tag, "/rd_fall"}, rd1, m_rd[1]);
    check_output({tag, "/rd_any"},  rd2, m_rd[2]);
    check_output({tag, "/irq_rise"}, {31'h0, irq0}, {31'h0, |(m_cap[0] & m_mask)});
    check_output({tag, "/irq_fall"}, {31'h0, irq1}, {31'h0, |(m_cap[1] & m_mask)});
    check_output({tag, "/irq_any"},  {31'h0, irq2}, {31'h0, |(m_cap[2] & m_mask)});
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    pio_in     = 32'hFFFF_FFFF;
    apply_stimulus(1'b0, 1'b0, 2'd0, 32'h0);
    tick();
    tick();
    check_output("reset_rd", rd0, 32'h0);
    check_output("reset_irq", {31'h0, irq0}, 32'h0);

    // Inputs held high through reset must not produce a capture.
    reset_n = 1'b1;
    repeat (10) tick();
    do_read(2'd3);
    check_output("hi_reset_cap_rise", rd0, 32'h0);
    check_output("hi_reset_cap_fall", rd1, 32'h0);
    check_output("hi_reset_cap_any", rd2, 32'h0);
    check_output("hi_reset_irq", {31'h0, irq0}, 32'h0);
    check_model("step1a");
    do_read(2'd0);
    check_output("hi_reset_data", rd0, 32'hFFFF_FFFF);
    check_model("step1b");

    // Rising capture latency and the write-1-to-clear path.
    pio_in = 32'h0;
    repeat (5) tick();
    pio_in = 32'h0000_00A5;
    tick();
    tick();
    do_read(2'd3);
    check_output("cap_not_yet", rd0, 32'h0);
    check_model("step2a");
    do_read(2'd3);
    check_output("cap_a5", rd0, 32'h0000_00A5);
    do_write(2'd2, 32'h1);
    check_output("irq_set", {31'h0, irq0}, 32'h1);
    check_model("step2b");
    do_write(2'd3, 32'h1);
    do_read(2'd3);
    check_output("cap_a4", rd0, 32'h0000_00A4);
    check_output("irq_clr", {31'h0, irq0}, 32'h0);
    check_model("step2c");

    // Falling edge on bit 3 lands in the same cycle as its clear.
    pio_in = 32'h0000_00AD;
    repeat (5) tick();
    do_write(2'd3, 32'hFFFF_FFFF);
    tick();
    pio_in = 32'h0000_00A5;
    tick();
    tick();
    apply_stimulus(1'b0, 1'b1, 2'd3, 32'h8);
    tick();
    apply_stimulus(1'b0, 1'b0, 2'd0, 32'h0);
    do_read(2'd3);
    check_output("edge_beats_clear", rd1 & 32'h8, 32'h8);
    check_model("step3");

    // Data readback and reserved address.
    pio_in = 32'h1234_5678;
    repeat (4) tick();
    do_read(2'd0);
    check_output("data_read", rd0, 32'h1234_5678);
    do_read(2'd1);
    check_output("reserved_read", rd0, 32'h0);
    check_model("step4");

    // Any-edge: two toggles of bit 31 set the bit once and it stays set.
    do_write(2'd3, 32'hFFFF_FFFF);
    repeat (4) tick();
    pio_in = pio_in ^ 32'h8000_0000;
    repeat (5) tick();
    pio_in = pio_in ^ 32'h8000_0000;
    repeat (5) tick();
    do_read(2'd3);
    check_output("any_bit31", rd2, 32'h8000_0000);
    repeat (3) tick();
    do_read(2'd3);
    check_output("any_bit31_held", rd2, 32'h8000_0000);
    do_write(2'd3, 32'h8000_0000);
    do_read(2'd3);
    check_output("any_bit31_clr", rd2, 32'h0);
    check_model("step5");

    // Asynchronous reset between clock edges with a pending interrupt.
    pio_in = 32'h0;
    repeat (4) tick();
    do_write(2'd3, 32'hFFFF_FFFF);
    do_write(2'd2, 32'hF);
    pio_in = 32'hF;
    repeat (4) tick();
    do_read(2'd3);
    check_output("pre_reset_cap", rd0, 32'hF);
    check_output("pre_reset_irq", {31'h0, irq0}, 32'h1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_rd", rd0, 32'h0);
    check_output("async_irq", {31'h0, irq0}, 32'h0);
    check_model("step6a");
    @(negedge clk);
    tick();
    reset_n = 1'b1;
    do_read(2'd2);
    check_output("mask_after_reset", rd0, 32'h0);
    do_read(2'd3);
    check_output("cap_after_reset", rd0, 32'h0);
    check_model("step6b");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) pio_in = $urandom;
      else pio_in = pio_in ^ ($urandom & $urandom & $urandom);
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                     2'($urandom_range(0, 3)), $urandom & $urandom);
      tick();
      check_model("random");
    end
    apply_stimulus(1'b0, 1'b0, 2'd0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
